// File: rtl/aes128_encrypt.sv
// Fully unrolled AES-128 encryption pipeline with on-the-fly round-key expansion.
// One block per clock; ciphertext and valid_out appear 11 edges after valid_in is sampled.
module aes128_encrypt (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         valid_out,
  output logic [127:0] ciphertext
);

  localparam logic [0:255][7:0] sbox_lut = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [1:10][7:0] rcon_lut = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[i*8 +: 8] = sbox_lut[s[i*8 +: 8]];
    return o;
  endfunction

  // Byte n of the block sits at bits [127-8n -: 8]; n = row + 4*column.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] w3, rot, temp, n0, n1, n2, n3;
    w3   = rk[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox_lut[rot[31:24]], sbox_lut[rot[23:16]], sbox_lut[rot[15:8]], sbox_lut[rot[7:0]]}
           ^ {rcon, 24'h000000};
    n0   = rk[127:96] ^ temp;
    n1   = rk[95:64] ^ n0;
    n2   = rk[63:32] ^ n1;
    n3   = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] state_q   [0:10];
  logic [127:0] rk_q      [0:9];
  logic [10:0]  valid_q;
  logic [127:0] rk_next   [1:10];
  logic [127:0] round_out [1:10];

  for (genvar i = 1; i <= 10; i++) begin : g_round
    assign rk_next[i] = next_round_key(rk_q[i-1], rcon_lut[i]);
    if (i < 10) begin : g_full
      assign round_out[i] = mix_columns(shift_rows(sub_bytes(state_q[i-1]))) ^ rk_next[i];
    end else begin : g_final
      assign round_out[i] = shift_rows(sub_bytes(state_q[i-1])) ^ rk_next[i];
    end
  end

  // Data and keys advance unconditionally; only valid_q gives them meaning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= 10; i++) state_q[i] <= '0;
      for (int i = 0; i <= 9; i++) rk_q[i] <= '0;
      valid_q    <= '0;
      valid_out  <= 1'b0;
      ciphertext <= '0;
    end else begin
      state_q[0] <= plaintext ^ key;
      rk_q[0]    <= key;
      valid_q    <= {valid_q[9:0], valid_in};
      for (int i = 1; i <= 10; i++) state_q[i] <= round_out[i];
      for (int i = 1; i <= 9; i++) rk_q[i] <= rk_next[i];
      valid_out  <= valid_q[10];
      ciphertext <= state_q[10];
    end
  end

endmodule

// File: tb/tb_aes128_encrypt.sv
// Directed bench for aes128_encrypt using FIPS-197 known-answer vectors.
// Checks exact valid_out timing, ordering, bubbles and mid-stream reset.
module tb_aes128_encrypt;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         valid_out;
  logic [127:0] ciphertext;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         s_vld [0:7];
  logic [127:0] s_pt  [0:7];
  logic [127:0] s_key [0:7];
  logic [127:0] s_ct  [0:7];

  always #5 clk = ~clk;

  aes128_encrypt dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .plaintext  (plaintext),
    .key        (key),
    .valid_out  (valid_out),
    .ciphertext (ciphertext)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int idx, input logic v, input logic [127:0] pt,
                          input logic [127:0] k, input logic [127:0] ct);
    s_vld[idx] = v;
    s_pt[idx]  = pt;
    s_key[idx] = k;
    s_ct[idx]  = ct;
  endtask

  // Idle slots carry random data so that only valid_in can create an output pulse.
  task automatic drive_slot(input int idx, input int len);
    if (idx < len && s_vld[idx]) begin
      valid_in  = 1'b1;
      plaintext = s_pt[idx];
      key       = s_key[idx];
    end else begin
      valid_in  = 1'b0;
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Slot j is sampled at edge N+j; its result must be seen right after edge N+j+11.
  task automatic run_stream(input string name, input int len, input int window);
    int   j;
    logic exp_v;
    @(negedge clk);
    drive_slot(0, len);
    for (int c = 0; c < window; c++) begin
      @(negedge clk);
      drive_slot(c + 1, len);
      j     = c - 11;
      exp_v = (j >= 0 && j < len) ? s_vld[j] : 1'b0;
      check($sformatf("%s valid_out c%0d", name, c), {127'b0, valid_out}, {127'b0, exp_v});
      if (exp_v)
        check($sformatf("%s ciphertext c%0d", name, c), ciphertext, s_ct[j]);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    plaintext = '0;
    key       = '0;
    #2;
    check("reset valid_out", {127'b0, valid_out}, 128'h0);
    check("reset ciphertext", ciphertext, 128'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    set_slot(0, 1'b1, PT_B, KEY_B, CT_B);
    run_stream("appB", 1, 21);

    set_slot(0, 1'b1, PT_C, KEY_C, CT_C);
    run_stream("appC1", 1, 14);

    set_slot(0, 1'b1, '0, '0, CT_Z);
    run_stream("zero", 1, 14);

    set_slot(0, 1'b1, PT_B, KEY_B, CT_B);
    set_slot(1, 1'b1, PT_C, KEY_C, CT_C);
    set_slot(2, 1'b1, '0, '0, CT_Z);
    run_stream("b2b", 3, 16);

    set_slot(0, 1'b1, PT_C, KEY_C, CT_C);
    set_slot(1, 1'b0, '0, '0, '0);
    set_slot(2, 1'b1, PT_B, KEY_B, CT_B);
    run_stream("bubble", 3, 16);

    // Mid-stream reset: the in-flight block must vanish without a pulse.
    @(negedge clk);
    valid_in  = 1'b1;
    plaintext = PT_B;
    key       = KEY_B;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive_slot(1, 0);
    end
    rst_n = 1'b0;
    #1;
    check("midreset valid_out", {127'b0, valid_out}, 128'h0);
    check("midreset ciphertext", ciphertext, 128'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("postreset valid_out c%0d", c), {127'b0, valid_out}, 128'h0);
    end

    set_slot(0, 1'b1, PT_C, KEY_C, CT_C);
    run_stream("recover", 1, 14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
